// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: pixel/line counters, active-low syncs, display
// window, frame-start pulse and a per-frame scroll offset for animated patterns.
// Every output is a flop whose next value is decoded from the next-state counters,
// so the flags always describe the pix_x/pix_y presented in the same cycle.
module vga_timing_gen #(
   parameter int unsigned H_DISPLAY   = 640,
   parameter int unsigned H_FRONT     = 16,
   parameter int unsigned H_SYNC      = 96,
   parameter int unsigned H_BACK      = 48,
   parameter int unsigned V_DISPLAY   = 480,
   parameter int unsigned V_FRONT     = 10,
   parameter int unsigned V_SYNC      = 2,
   parameter int unsigned V_BACK      = 33,
   parameter int unsigned SCROLL_STEP = 1,
   parameter int unsigned OFFSET_WRAP = 40
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       ena,
   input  logic       scroll_en,
   output logic [9:0] pix_x,
   output logic [9:0] pix_y,
   output logic       hsync,
   output logic       vsync,
   output logic       display_on,
   output logic       frame_start,
   output logic [9:0] x_offset
);

   // Totals must fit the 10-bit counters (<= 1024); SCROLL_STEP must be < OFFSET_WRAP.
   localparam int unsigned H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
   localparam int unsigned V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;

   localparam logic [9:0]  HMax       = 10'(H_TOTAL - 1);
   localparam logic [9:0]  VMax       = 10'(V_TOTAL - 1);
   // Window bounds are 11 bits so an end bound of exactly 1024 still compares correctly.
   localparam logic [10:0] HDisp      = 11'(H_DISPLAY);
   localparam logic [10:0] VDisp      = 11'(V_DISPLAY);
   localparam logic [10:0] HSyncStart = 11'(H_DISPLAY + H_FRONT);
   localparam logic [10:0] HSyncEnd   = 11'(H_DISPLAY + H_FRONT + H_SYNC);
   localparam logic [10:0] VSyncStart = 11'(V_DISPLAY + V_FRONT);
   localparam logic [10:0] VSyncEnd   = 11'(V_DISPLAY + V_FRONT + V_SYNC);
   localparam logic [10:0] Step       = 11'(SCROLL_STEP);
   localparam logic [10:0] Wrap       = 11'(OFFSET_WRAP);

   logic [9:0]  pix_x_q, pix_x_d;
   logic [9:0]  pix_y_q, pix_y_d;
   logic [9:0]  x_offset_q, x_offset_d;
   logic        hsync_q, hsync_d;
   logic        vsync_q, vsync_d;
   logic        display_on_q, display_on_d;
   logic        frame_start_q, frame_start_d;
   logic [10:0] offset_sum;
   logic [10:0] x_ext, y_ext;

   // Counter advance, frame wrap and scroll offset update.
   always_comb begin
      pix_x_d       = pix_x_q;
      pix_y_d       = pix_y_q;
      x_offset_d    = x_offset_q;
      frame_start_d = 1'b0;
      offset_sum    = {1'b0, x_offset_q} + Step;
      if (offset_sum >= Wrap) begin
         offset_sum = offset_sum - Wrap;
      end
      if (ena) begin
         if (pix_x_q == HMax) begin
            pix_x_d = '0;
            if (pix_y_q == VMax) begin
               pix_y_d       = '0;
               frame_start_d = 1'b1;
               if (scroll_en) begin
                  x_offset_d = offset_sum[9:0];
               end
            end else begin
               pix_y_d = pix_y_q + 10'd1;
            end
         end else begin
            pix_x_d = pix_x_q + 10'd1;
         end
      end
   end

   // Sync and display flags decoded from the next-state position.
   always_comb begin
      x_ext        = {1'b0, pix_x_d};
      y_ext        = {1'b0, pix_y_d};
      hsync_d      = !((x_ext >= HSyncStart) && (x_ext < HSyncEnd));
      vsync_d      = !((y_ext >= VSyncStart) && (y_ext < VSyncEnd));
      display_on_d = (x_ext < HDisp) && (y_ext < VDisp);
   end

   // State registers; reset places the raster at (0,0) with syncs idle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pix_x_q       <= '0;
         pix_y_q       <= '0;
         x_offset_q    <= '0;
         hsync_q       <= 1'b1;
         vsync_q       <= 1'b1;
         display_on_q  <= 1'b1;
         frame_start_q <= 1'b0;
      end else begin
         pix_x_q       <= pix_x_d;
         pix_y_q       <= pix_y_d;
         x_offset_q    <= x_offset_d;
         hsync_q       <= hsync_d;
         vsync_q       <= vsync_d;
         display_on_q  <= display_on_d;
         frame_start_q <= frame_start_d;
      end
   end

   assign pix_x       = pix_x_q;
   assign pix_y       = pix_y_q;
   assign x_offset    = x_offset_q;
   assign hsync       = hsync_q;
   assign vsync       = vsync_q;
   assign display_on  = display_on_q;
   assign frame_start = frame_start_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: a full-size 640x480 instance and a reduced-timing
// instance (12x7 raster) share stimulus. A reference model pushes the expected
// state per edge into a queue; a monitor pops and compares after every edge.
module tb_vga_timing_gen;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       ena = 1'b0;
   logic       scroll_en = 1'b1;

   logic [9:0] f_x, f_y, f_off;
   logic       f_hs, f_vs, f_de, f_fs;
   logic [9:0] s_x, s_y, s_off;
   logic       s_hs, s_vs, s_de, s_fs;

   int n_checks = 0;
   int n_fail   = 0;

   typedef struct packed {
      logic [9:0] x;
      logic [9:0] y;
      logic       hs;
      logic       vs;
      logic       de;
      logic       fs;
      logic [9:0] off;
   } st_t;

   localparam st_t RST = '{x: 10'd0, y: 10'd0, hs: 1'b1, vs: 1'b1, de: 1'b1, fs: 1'b0,
                           off: 10'd0};

   st_t prev_f = RST;
   st_t prev_s = RST;
   st_t q_f[$];
   st_t q_s[$];

   vga_timing_gen dut_full (
      .clk         (clk),
      .rst_n       (rst_n),
      .ena         (ena),
      .scroll_en   (scroll_en),
      .pix_x       (f_x),
      .pix_y       (f_y),
      .hsync       (f_hs),
      .vsync       (f_vs),
      .display_on  (f_de),
      .frame_start (f_fs),
      .x_offset    (f_off)
   );

   vga_timing_gen #(
      .H_DISPLAY (8),
      .H_FRONT   (1),
      .H_SYNC    (2),
      .H_BACK    (1),
      .V_DISPLAY (4),
      .V_FRONT   (1),
      .V_SYNC    (1),
      .V_BACK    (1)
   ) dut_small (
      .clk         (clk),
      .rst_n       (rst_n),
      .ena         (ena),
      .scroll_en   (scroll_en),
      .pix_x       (s_x),
      .pix_y       (s_y),
      .hsync       (s_hs),
      .vsync       (s_vs),
      .display_on  (s_de),
      .frame_start (s_fs),
      .x_offset    (s_off)
   );

   always #5 clk = ~clk;

   function automatic st_t get_full();
      return {f_x, f_y, f_hs, f_vs, f_de, f_fs, f_off};
   endfunction

   function automatic st_t get_small();
      return {s_x, s_y, s_hs, s_vs, s_de, s_fs, s_off};
   endfunction

   // Reference model: state after one enabled/disabled clock edge.
   function automatic st_t model_next(input st_t p, input logic en, input logic sc,
                                      input int ht, input int vt, input int hd,
                                      input int hf, input int hsw, input int vd,
                                      input int vf, input int vsw);
      st_t  n;
      int   x, y, o;
      logic wrap;
      n = p;
      if (!en) begin
         n.fs = 1'b0;
         return n;
      end
      x    = int'(p.x);
      y    = int'(p.y);
      o    = int'(p.off);
      wrap = (x == ht - 1) && (y == vt - 1);
      if (x == ht - 1) begin
         x = 0;
         y = (y == vt - 1) ? 0 : y + 1;
      end else begin
         x = x + 1;
      end
      if (wrap && sc) o = (o + 1) % 40;
      n.x   = 10'(x);
      n.y   = 10'(y);
      n.off = 10'(o);
      n.hs  = !((x >= hd + hf) && (x < hd + hf + hsw));
      n.vs  = !((y >= vd + vf) && (y < vd + vf + vsw));
      n.de  = (x < hd) && (y < vd);
      n.fs  = wrap;
      return n;
   endfunction

   task automatic push_expected();
      st_t nf, ns;
      if (!rst_n) begin
         nf = RST;
         ns = RST;
      end else begin
         nf = model_next(prev_f, ena, scroll_en, 800, 525, 640, 16, 96, 480, 10, 2);
         ns = model_next(prev_s, ena, scroll_en, 12, 7, 8, 1, 2, 4, 1, 1);
      end
      q_f.push_back(nf);
      q_s.push_back(ns);
      prev_f = nf;
      prev_s = ns;
   endtask

   task automatic cycle();
      push_expected();
      @(negedge clk);
   endtask

   // Scoreboard monitor: compare both instances against the model after each edge.
   always @(posedge clk) begin
      st_t e, a;
      #1;
      if (q_f.size() > 0) begin
         e = q_f.pop_front();
         a = get_full();
         n_checks++;
         if (a !== e) begin
            n_fail++;
            $display("FAIL sb_full t=%0t: got x=%0d y=%0d hs=%b vs=%b de=%b fs=%b off=%0d, expected x=%0d y=%0d hs=%b vs=%b de=%b fs=%b off=%0d",
                     $time, a.x, a.y, a.hs, a.vs, a.de, a.fs, a.off,
                     e.x, e.y, e.hs, e.vs, e.de, e.fs, e.off);
         end
      end
      if (q_s.size() > 0) begin
         e = q_s.pop_front();
         a = get_small();
         n_checks++;
         if (a !== e) begin
            n_fail++;
            $display("FAIL sb_small t=%0t: got x=%0d y=%0d hs=%b vs=%b de=%b fs=%b off=%0d, expected x=%0d y=%0d hs=%b vs=%b de=%b fs=%b off=%0d",
                     $time, a.x, a.y, a.hs, a.vs, a.de, a.fs, a.off,
                     e.x, e.y, e.hs, e.vs, e.de, e.fs, e.off);
         end
      end
   end

   task automatic apply_reset();
      rst_n = 1'b0;
      cycle();
      cycle();
      rst_n = 1'b1;
   endtask

   // Advance the small raster until it sits at (x,y) (and offset, if asked).
   task automatic wait_small(input int x, input int y, input int off, input bit use_off,
                             input int budget, output bit found);
      st_t s;
      found = 1'b0;
      for (int i = 0; i < budget; i++) begin
         s = get_small();
         if (int'(s.x) == x && int'(s.y) == y && (!use_off || int'(s.off) == off)) begin
            found = 1'b1;
            return;
         end
         cycle();
      end
   endtask

   task automatic test_reset();
      st_t a;
      rst_n     = 1'b0;
      ena       = 1'b1;
      scroll_en = 1'b1;
      cycle();
      cycle();
      cycle();
      a = get_full();
      n_checks++;
      if (a !== RST) begin
         n_fail++;
         $display("FAIL reset_full: got %h, expected %h", a, RST);
      end
      a = get_small();
      n_checks++;
      if (a !== RST) begin
         n_fail++;
         $display("FAIL reset_small: got %h, expected %h", a, RST);
      end
      rst_n = 1'b1;
   endtask

   task automatic test_line();
      st_t a;
      int  hs_low = 0, hs_min = 9999, hs_max = -1, de_low = 0;
      for (int i = 0; i < 800; i++) begin
         cycle();
         a = get_full();
         if (!a.hs) begin
            hs_low++;
            if (int'(a.x) < hs_min) hs_min = int'(a.x);
            if (int'(a.x) > hs_max) hs_max = int'(a.x);
         end
         if (a.y == 10'd0 && !a.de) de_low++;
      end
      n_checks++;
      if (a.x !== 10'd0 || a.y !== 10'd1) begin
         n_fail++;
         $display("FAIL line_wrap: got x=%0d y=%0d, expected x=0 y=1", a.x, a.y);
      end
      n_checks++;
      if (hs_low != 96) begin
         n_fail++;
         $display("FAIL line_hsync_len: got %0d, expected 96", hs_low);
      end
      n_checks++;
      if (hs_min != 656 || hs_max != 751) begin
         n_fail++;
         $display("FAIL line_hsync_span: got %0d..%0d, expected 656..751", hs_min, hs_max);
      end
      n_checks++;
      if (de_low != 160) begin
         n_fail++;
         $display("FAIL line_blank_len: got %0d, expected 160", de_low);
      end
   endtask

   task automatic test_scroll_wrap();
      st_t s;
      int  fs_cnt = 0, vs_low = 0, first_fs = -1;
      apply_reset();
      scroll_en = 1'b1;
      for (int i = 0; i < 40 * 84; i++) begin
         cycle();
         s = get_small();
         if (i < 84 && !s.vs) vs_low++;
         if (s.fs) begin
            fs_cnt++;
            if (first_fs < 0) first_fs = i;
            n_checks++;
            if (s.x !== 10'd0 || s.y !== 10'd0 || int'(s.off) != fs_cnt % 40) begin
               n_fail++;
               $display("FAIL scroll_pulse %0d: got x=%0d y=%0d off=%0d, expected x=0 y=0 off=%0d",
                        fs_cnt, s.x, s.y, s.off, fs_cnt % 40);
            end
         end
      end
      n_checks++;
      if (fs_cnt != 40 || s.off !== 10'd0) begin
         n_fail++;
         $display("FAIL scroll_wrap: got pulses=%0d off=%0d, expected pulses=40 off=0",
                  fs_cnt, s.off);
      end
      n_checks++;
      if (first_fs != 83) begin
         n_fail++;
         $display("FAIL first_frame_pulse: got cycle %0d, expected 83", first_fs);
      end
      n_checks++;
      if (vs_low != 12) begin
         n_fail++;
         $display("FAIL vsync_len: got %0d, expected 12", vs_low);
      end
   endtask

   task automatic test_scroll_hold();
      st_t s;
      bit  found;
      int  off0;
      wait_small(11, 6, 0, 1'b0, 200, found);
      n_checks++;
      if (!found) begin
         n_fail++;
         $display("FAIL hold_reach: got found=0, expected found=1");
      end
      off0      = int'(get_small().off);
      scroll_en = 1'b0;
      cycle();
      scroll_en = 1'b1;
      s = get_small();
      n_checks++;
      if (s.fs !== 1'b1 || int'(s.off) != off0) begin
         n_fail++;
         $display("FAIL hold_offset: got fs=%b off=%0d, expected fs=1 off=%0d", s.fs, s.off, off0);
      end
      wait_small(11, 6, 0, 1'b0, 200, found);
      cycle();
      s = get_small();
      n_checks++;
      if (int'(s.off) != (off0 + 1) % 40) begin
         n_fail++;
         $display("FAIL hold_resume: got off=%0d, expected %0d", s.off, (off0 + 1) % 40);
      end
   endtask

   task automatic test_ena_freeze();
      st_t s, held;
      bit  found;
      wait_small(11, 6, 0, 1'b0, 200, found);
      n_checks++;
      if (!found) begin
         n_fail++;
         $display("FAIL freeze_reach: got found=0, expected found=1");
      end
      held = get_small();
      ena  = 1'b0;
      for (int i = 0; i < 10; i++) begin
         cycle();
         s = get_small();
         n_checks++;
         if (s !== held) begin
            n_fail++;
            $display("FAIL freeze_hold %0d: got %h, expected %h", i, s, held);
         end
      end
      ena = 1'b1;
      cycle();
      s = get_small();
      n_checks++;
      if (s.x !== 10'd0 || s.y !== 10'd0 || s.fs !== 1'b1 ||
          int'(s.off) != (int'(held.off) + 1) % 40) begin
         n_fail++;
         $display("FAIL freeze_resume: got x=%0d y=%0d fs=%b off=%0d, expected x=0 y=0 fs=1 off=%0d",
                  s.x, s.y, s.fs, s.off, (int'(held.off) + 1) % 40);
      end
   endtask

   task automatic test_reset_mid();
      st_t s;
      bit  found;
      wait_small(5, 3, 5, 1'b1, 4000, found);
      n_checks++;
      if (!found) begin
         n_fail++;
         $display("FAIL midreset_reach: got found=0, expected found=1");
      end
      push_expected();
      @(posedge clk);
      #3;
      rst_n = 1'b0;
      #1;
      s = get_small();
      n_checks++;
      if (s !== RST) begin
         n_fail++;
         $display("FAIL midreset_small: got %h, expected %h", s, RST);
      end
      s = get_full();
      n_checks++;
      if (s !== RST) begin
         n_fail++;
         $display("FAIL midreset_full: got %h, expected %h", s, RST);
      end
      prev_f = RST;
      prev_s = RST;
      @(negedge clk);
      cycle();
      cycle();
      rst_n = 1'b1;
      for (int k = 1; k <= 3; k++) begin
         cycle();
         s = get_small();
         n_checks++;
         if (int'(s.x) != k || s.y !== 10'd0) begin
            n_fail++;
            $display("FAIL midreset_count %0d: got x=%0d y=%0d, expected x=%0d y=0",
                     k, s.x, s.y, k);
         end
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      test_reset();
      test_line();
      test_scroll_wrap();
      test_scroll_hold();
      test_ena_freeze();
      test_reset_mid();
      cycle();
      cycle();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
